// File: rtl/serial_sub_sequencer.sv
// Bit-serial unsigned subtractor: one bit per clock through a registered borrow.
// Optional macro SUB_SATURATE_EN clamps an underflowing result to zero.
module serial_sub_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Difference,
  output logic             Borrow,
  output logic             Zero
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             bit_a, bit_b, d, br_next, last_bit;
  logic [WIDTH-1:0] res_full, final_diff;

  always_comb begin
    bit_a    = a_sh[0];
    bit_b    = b_sh[0];
    d        = bit_a ^ bit_b ^ br;
    br_next  = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br);
    last_bit = (cnt == CW'(WIDTH - 1));
    res_full = {d, res_sh[WIDTH-1:1]};
`ifdef SUB_SATURATE_EN
    final_diff = br_next ? '0 : res_full;
`else
    final_diff = res_full;
`endif
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    Busy       = 1'b0;
    Done       = 1'b0;
    case (state)
      IDLE: if (Start) state_next = RUN;
      RUN: begin
        Busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        Done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operands shift right; each new difference bit enters at the MSB so the
  // first-computed bit lands at the LSB after WIDTH steps.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      Difference <= '0;
      Borrow     <= 1'b0;
      Zero       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (Start) begin
          a_sh   <= A;
          b_sh   <= B;
          res_sh <= '0;
          br     <= 1'b0;
          cnt    <= '0;
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_full;
          br     <= br_next;
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            Difference <= final_diff;
            Borrow     <= br_next;
            Zero       <= (final_diff == '0);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_sub_sequencer.sv
// Scoreboard bench for serial_sub_sequencer: stimulus pushes expected results,
// a negedge monitor pops and compares on every Done pulse.
module tb_serial_sub_sequencer;
  localparam int WIDTH = 4;

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic             Start = 1'b0;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic             Busy, Done, Borrow, Zero;
  logic [WIDTH-1:0] Difference;

  serial_sub_sequencer #(.WIDTH(WIDTH)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .Difference(Difference),
    .Borrow(Borrow), .Zero(Zero)
  );

  always #5 Clk = ~Clk;

  // expected entry: {difference, borrow, zero}
  logic [WIDTH+1:0] exp_q[$];
  logic             finish_req = 1'b0;

  task automatic push_exp(input logic [WIDTH-1:0] d, input logic br, input logic z);
    exp_q.push_back({d, br, z});
  endtask

  // one Start pulse, then wait out the full issue interval
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] d, input logic br, input logic z);
    @(negedge Clk);
    A = a; B = b; Start = 1'b1;
    push_exp(d, br, z);
    @(negedge Clk);
    Start = 1'b0;
    repeat (5) @(negedge Clk);
  endtask

  // Monitor: owns all check/error counters
  initial begin : monitor
    int errors, checks, busy_run, op;
    logic [WIDTH+1:0] e;
    logic prev_done;
    errors = 0; checks = 0; busy_run = 0; op = 0; prev_done = 1'b0;
    forever begin
      @(negedge Clk);
      if (finish_req) begin
        checks++;
        if (exp_q.size() != 0) begin
          errors++;
          $display("FAIL pending: %0d expected results never produced, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
      if (Reset) begin
        busy_run = 0;
        checks++;
        if ({Busy, Done, Difference, Borrow, Zero} != '0) begin
          errors++;
          $display("FAIL reset_outputs: busy=%b done=%b diff=%0d borrow=%b zero=%b, required all 0",
                   Busy, Done, Difference, Borrow, Zero);
        end
      end else begin
        if (Busy) busy_run++;
        if (Done) begin
          op++;
          checks++;
          if (prev_done) begin
            errors++;
            $display("FAIL done_width: op %0d done high two cycles, required one", op);
          end
          checks++;
          if (busy_run != WIDTH) begin
            errors++;
            $display("FAIL busy_len: op %0d busy=%0d cycles, required %0d", op, busy_run, WIDTH);
          end
          busy_run = 0;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: op %0d diff=%0d with no request pending, required none", op, Difference);
          end else begin
            e = exp_q.pop_front();
            checks += 3;
            if (Difference != e[WIDTH+1:2]) begin
              errors++;
              $display("FAIL difference: op %0d got %0d, required %0d", op, Difference, e[WIDTH+1:2]);
            end
            if (Borrow != e[1]) begin
              errors++;
              $display("FAIL borrow: op %0d got %b, required %b", op, Borrow, e[1]);
            end
            if (Zero != e[0]) begin
              errors++;
              $display("FAIL zero: op %0d got %b, required %b", op, Zero, e[0]);
            end
            $display("op %0d: diff=%0d borrow=%b zero=%b", op, Difference, Borrow, Zero);
          end
        end
        prev_done = Done;
      end
    end
  end

  initial begin : stimulus
    repeat (3) @(negedge Clk);
    Reset = 1'b0;

    run_op(4'd9, 4'd5, 4'd4, 1'b0, 1'b0);
`ifdef SUB_SATURATE_EN
    run_op(4'd3, 4'd5, 4'd0, 1'b1, 1'b1);
`else
    run_op(4'd3, 4'd5, 4'd14, 1'b1, 1'b0);
`endif
    run_op(4'd7, 4'd7, 4'd0, 1'b0, 1'b1);
`ifdef SUB_SATURATE_EN
    run_op(4'd0, 4'd15, 4'd0, 1'b1, 1'b1);
`else
    run_op(4'd0, 4'd15, 4'd1, 1'b1, 1'b0);
`endif
    run_op(4'd15, 4'd0, 4'd15, 1'b0, 1'b0);

    // second Start during RUN must be ignored
    @(negedge Clk);
    A = 4'd9; B = 4'd5; Start = 1'b1;
    push_exp(4'd4, 1'b0, 1'b0);
    @(negedge Clk);
    Start = 1'b0;
    @(negedge Clk);
    A = 4'd1; B = 4'd1; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (6) @(negedge Clk);

    // Start held high: back-to-back operations every WIDTH+2 cycles
    @(negedge Clk);
    A = 4'd12; B = 4'd3; Start = 1'b1;
    repeat (3) push_exp(4'd9, 1'b0, 1'b0);
    repeat (18) @(negedge Clk);
    Start = 1'b0;
    repeat (4) @(negedge Clk);

    // leave a nonzero result, then abort an operation after two RUN edges
    run_op(4'd9, 4'd5, 4'd4, 1'b0, 1'b0);
    @(negedge Clk);
    A = 4'd9; B = 4'd5; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (2) @(posedge Clk);
    #2 Reset = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (8) @(negedge Clk);

    run_op(4'd10, 4'd3, 4'd7, 1'b0, 1'b0);
    repeat (2) @(negedge Clk);
    finish_req = 1'b1;
    repeat (4) @(negedge Clk);
    $display("FAIL timeout: monitor did not finish, required summary");
    $fatal(1, "bench did not terminate");
  end
endmodule
